pc_sequencer: RTL and testbench
===============================

// Module: pc_sequencer
// PURPOSE
//  Fetch/decode/execute control FSM that drives the 8-bit program counter's en_PC, load_en and load inputs.
//  Sequences every instruction: one fetch, one decode, one execute cycle, plus any stall cycles.
//  Resolves jumps, zero-flag branches, calls and returns.
//  Calls and returns use an internal hardware return-address stack.
//  Sits between program memory / instruction decoder and the PC register.
// PARAMETERS
//  AW           8   address width; matches PC width
//  STACK_DEPTH  4   return-address stack entries
//  SP_W         3   stack-pointer width; holds 0..STACK_DEPTH
// PORTS
//  clk         in   1    system clock; all state updates on posedge
//  reset       in   1    synchronous, active-high; highest priority
//  pc          in   AW   current PC value, fed back from the PC register
//  instr_valid in   1    program-memory word at pc is valid
//  op_class    in   3    decoded class: 0 SEQ, 1 JMP, 2 CALL, 3 RET, 4 BRZ, 5 HALT; 6-7 act as SEQ
//  target      in   AW   jump/branch/call destination from the decoder
//  zero_flag   in   1    ALU zero flag, sampled in EXECUTE
//  stall       in   1    holds EXECUTE, e.g. for a multi-cycle ALU op
//  ir_load     out  1    latch the instruction register
//  en_PC       out  1    PC increment
//  load_en     out  1    PC load
//  load        out  AW   PC load value
//  halted      out  1    FSM is in HALT
//  stack_ovf   out  1    sticky: CALL issued with the stack full
//  stack_unf   out  1    sticky: RET issued with the stack empty
//  state       out  2    debug: current FSM state
// BEHAVIOUR
//  Reset values: state=FETCH, sp=0, stack_ovf=0, stack_unf=0, halted=0.
//    All strobe outputs are 0 and load=0 during the reset cycle.
//    Reset mid-instruction aborts that instruction; the PC itself is reset separately.
//  States (encoding): FETCH=0, DECODE=1, EXECUTE=2, HALT=3.
//  FETCH
//    instr_valid=1: ir_load=1 for one cycle, next state DECODE.
//    instr_valid=0: stay in FETCH, no strobes.
//  DECODE: unconditional, one cycle, no strobes; next state EXECUTE.
//  EXECUTE with stall=1: hold; en_PC=load_en=0; stack unchanged.
//  EXECUTE with stall=0: one action cycle, then next state FETCH (HALT for op 5).
//    SEQ : en_PC=1.
//    JMP : load_en=1, load=target.
//    BRZ : zero_flag=1 -> load_en=1, load=target; zero_flag=0 -> en_PC=1.
//    CALL, stack not full: push (pc+1) mod 2^AW; load_en=1, load=target.
//    CALL, stack full: set stack_ovf, no push, en_PC=1 (acts as SEQ).
//    RET, stack not empty: pop; load_en=1, load=popped address.
//    RET, stack empty: set stack_unf, en_PC=1.
//    HALT: no strobes; next state HALT.
//  HALT: absorbing; halted=1, no strobes; exits only on reset.
//  Strobes: en_PC, load_en and ir_load are combinational from the registered state and current inputs.
//    en_PC and load_en are never asserted together; at most one is high per instruction.
//    The PC register samples them on the same edge that leaves EXECUTE.
//  load is 0 whenever load_en=0.
//  Latency: minimum 3 cycles per instruction, plus instr_valid wait cycles and stall cycles.
//  Return address (pc+1) wraps: 8'hFF -> 8'h00.
//  sp counts 0..STACK_DEPTH; push writes entry[sp] then sp++; pop reads entry[sp-1] then sp--.
//  Stack contents are not cleared by reset; only sp is.
//  Sticky flags clear only on reset.
// STRUCTURE
//  Shared package pc_seq_pkg holds:
//    op_class codes OP_SEQ..OP_HALT
//    state codes S_FETCH..S_HALT
//    localparams for AW and STACK_DEPTH
//  Sub-module return_stack (LIFO):
//    ports clk, reset, push, pop, din[AW], dout[AW], full, empty
//    pop data is combinationally valid in the same cycle.
//  Top level: FSM, action mux, flag registers.
// TESTING
//  1. Reset, then 3 SEQ with instr_valid=1 -> en_PC pulses at cycles 3, 6, 9; PC 0->1->2->3; no load_en.
//  2. JMP target=8'h40 at pc=5 -> EXECUTE cycle: load_en=1, load=8'h40, en_PC=0; next FETCH sees pc=8'h40.
//  3. BRZ target=8'h20: zero_flag=1 -> PC=8'h20; zero_flag=0 -> PC=pc+1.
//  4. CALL 8'h10 at pc=8'hFF, then RET -> pushed return address 8'h00; RET loads 8'h00.
//  5. 5 nested CALLs (depth 4) -> 5th CALL sets stack_ovf and increments PC instead of jumping.
//     Then 5 RETs -> 4 correct addresses in LIFO order; 5th RET sets stack_unf.
//  6. stall=1 for 4 cycles in EXECUTE -> no strobes, state=2 held.
//     Reset asserted mid-stall -> state=0, sp=0, flags cleared; next cycle resumes in FETCH.
//     HALT -> halted=1 until reset.

Source files
------------

// File: rtl/pc_seq_pkg.sv
// Shared constants for the PC sequencer: address/stack sizing, op classes and FSM state codes.
package pc_seq_pkg;

  localparam int unsigned AW          = 8;
  localparam int unsigned STACK_DEPTH = 4;
  localparam int unsigned SP_W        = 3;

  typedef enum logic [1:0] {
    S_FETCH   = 2'd0,
    S_DECODE  = 2'd1,
    S_EXECUTE = 2'd2,
    S_HALT    = 2'd3
  } state_t;

  localparam logic [2:0] OP_SEQ  = 3'd0;
  localparam logic [2:0] OP_JMP  = 3'd1;
  localparam logic [2:0] OP_CALL = 3'd2;
  localparam logic [2:0] OP_RET  = 3'd3;
  localparam logic [2:0] OP_BRZ  = 3'd4;
  localparam logic [2:0] OP_HALT = 3'd5;

endpackage

// File: rtl/return_stack.sv
// Hardware return-address LIFO; only the pointer is reset, pop data is valid combinationally.
module return_stack
  import pc_seq_pkg::*;
(
  input  logic          clk,
  input  logic          reset,
  input  logic          push,
  input  logic          pop,
  input  logic [AW-1:0] din,
  output logic [AW-1:0] dout,
  output logic          full,
  output logic          empty
);

  localparam int unsigned IDX_W = $clog2(STACK_DEPTH);

  logic [AW-1:0]   mem [STACK_DEPTH];
  logic [SP_W-1:0] sp;
  logic [SP_W-1:0] sp_m1;

  assign full  = (sp == SP_W'(STACK_DEPTH));
  assign empty = (sp == '0);
  assign sp_m1 = sp - SP_W'(1);
  assign dout  = mem[sp_m1[IDX_W-1:0]];

  always_ff @(posedge clk) begin
    if (reset) begin
      sp <= '0;
    end else if (push && !full) begin
      mem[sp[IDX_W-1:0]] <= din;
      sp                 <= sp + SP_W'(1);
    end else if (pop && !empty) begin
      sp <= sp_m1;
    end
  end

endmodule

// File: rtl/pc_sequencer.sv
// Fetch/decode/execute sequencer driving the PC register's increment/load controls,
// with jump, zero-flag branch and call/return handling through a hardware return stack.
module pc_sequencer
  import pc_seq_pkg::*;
(
  input  logic          clk,
  input  logic          reset,
  input  logic [AW-1:0] pc,
  input  logic          instr_valid,
  input  logic [2:0]    op_class,
  input  logic [AW-1:0] target,
  input  logic          zero_flag,
  input  logic          stall,
  output logic          ir_load,
  output logic          en_PC,
  output logic          load_en,
  output logic [AW-1:0] load,
  output logic          halted,
  output logic          stack_ovf,
  output logic          stack_unf,
  output logic [1:0]    state
);

  state_t        state_q;
  state_t        state_d;
  logic          push;
  logic          pop;
  logic          set_ovf;
  logic          set_unf;
  logic          stk_full;
  logic          stk_empty;
  logic [AW-1:0] stk_dout;
  logic [AW-1:0] ret_addr;

  assign ret_addr = pc + AW'(1);
  assign state    = state_q;
  assign halted   = (state_q == S_HALT);

  return_stack u_stack (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .din   (ret_addr),
    .dout  (stk_dout),
    .full  (stk_full),
    .empty (stk_empty)
  );

  // Next state and strobe decode; everything is forced idle while reset is held.
  always_comb begin
    state_d = state_q;
    ir_load = 1'b0;
    en_PC   = 1'b0;
    load_en = 1'b0;
    load    = '0;
    push    = 1'b0;
    pop     = 1'b0;
    set_ovf = 1'b0;
    set_unf = 1'b0;
    if (!reset) begin
      case (state_q)
        S_FETCH: begin
          if (instr_valid) begin
            ir_load = 1'b1;
            state_d = S_DECODE;
          end
        end
        S_DECODE: state_d = S_EXECUTE;
        S_EXECUTE: begin
          if (!stall) begin
            state_d = S_FETCH;
            case (op_class)
              OP_SEQ: en_PC = 1'b1;
              OP_JMP: begin
                load_en = 1'b1;
                load    = target;
              end
              OP_BRZ: begin
                if (zero_flag) begin
                  load_en = 1'b1;
                  load    = target;
                end else begin
                  en_PC = 1'b1;
                end
              end
              OP_CALL: begin
                if (!stk_full) begin
                  push    = 1'b1;
                  load_en = 1'b1;
                  load    = target;
                end else begin
                  set_ovf = 1'b1;
                  en_PC   = 1'b1;
                end
              end
              OP_RET: begin
                if (!stk_empty) begin
                  pop     = 1'b1;
                  load_en = 1'b1;
                  load    = stk_dout;
                end else begin
                  set_unf = 1'b1;
                  en_PC   = 1'b1;
                end
              end
              OP_HALT: state_d = S_HALT;
              default: en_PC = 1'b1;
            endcase
          end
        end
        S_HALT: state_d = S_HALT;
        default: state_d = S_FETCH;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_FETCH;
      stack_ovf <= 1'b0;
      stack_unf <= 1'b0;
    end else begin
      state_q <= state_d;
      if (set_ovf) stack_ovf <= 1'b1;
      if (set_unf) stack_unf <= 1'b1;
    end
  end

endmodule

// File: tb/tb_pc_sequencer.sv
// Randomized self-checking bench for pc_sequencer against an instruction-level reference model.
module tb_pc_sequencer;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] pc;
  logic       instr_valid;
  logic [2:0] op_class;
  logic [7:0] target;
  logic       zero_flag;
  logic       stall;
  logic       ir_load, en_PC, load_en, halted, stack_ovf, stack_unf;
  logic [7:0] load;
  logic [1:0] state;

  int n_checks = 0;
  int n_fail   = 0;

  // instruction-level reference model
  logic [7:0] model_pc;
  logic [7:0] model_stack[$];
  logic       model_ovf, model_unf;

  pc_sequencer dut (
    .clk         (clk),
    .reset       (reset),
    .pc          (pc),
    .instr_valid (instr_valid),
    .op_class    (op_class),
    .target      (target),
    .zero_flag   (zero_flag),
    .stall       (stall),
    .ir_load     (ir_load),
    .en_PC       (en_PC),
    .load_en     (load_en),
    .load        (load),
    .halted      (halted),
    .stack_ovf   (stack_ovf),
    .stack_unf   (stack_unf),
    .state       (state)
  );

  always #5 clk = ~clk;

  // PC register in the environment, driven by the DUT strobes
  always_ff @(posedge clk) begin
    if (reset)        pc <= 8'd0;
    else if (en_PC)   pc <= pc + 8'd1;
    else if (load_en) pc <= load;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic check_idle(input string tag, input logic [1:0] exp_state);
    check({tag, "_state"}, 32'(state), 32'(exp_state));
    check({tag, "_en"}, 32'(en_PC), 32'(0));
    check({tag, "_ld"}, 32'(load_en), 32'(0));
    check({tag, "_load"}, 32'(load), 32'(0));
  endtask

  task automatic check_arch(input string tag);
    check({tag, "_pc"}, 32'(pc), 32'(model_pc));
    check({tag, "_ovf"}, 32'(stack_ovf), 32'(model_ovf));
    check({tag, "_unf"}, 32'(stack_unf), 32'(model_unf));
  endtask

  task automatic do_reset();
    reset = 1'b1;
    instr_valid = 1'b1;
    stall = 1'b0;
    op_class = 3'd0;
    #1;
    check("rst_ir", 32'(ir_load), 32'(0));
    check("rst_en", 32'(en_PC), 32'(0));
    check("rst_ld", 32'(load_en), 32'(0));
    check("rst_load", 32'(load), 32'(0));
    step();
    reset = 1'b0;
    model_pc = 8'd0;
    model_stack.delete();
    model_ovf = 1'b0;
    model_unf = 1'b0;
    #1;
    check("post_rst_state", 32'(state), 32'(0));
    check("post_rst_halted", 32'(halted), 32'(0));
    check_arch("post_rst");
  endtask

  // One complete instruction: fetch waits, fetch, decode, stalls, execute.
  task automatic run_instr(input logic [2:0] op, input logic [7:0] tgt, input logic zf,
                           input int waits, input int stalls);
    logic       exp_en, exp_ld;
    logic [7:0] exp_load, next_pc;
    logic [1:0] exp_state;
    exp_en = 1'b0; exp_ld = 1'b0; exp_load = 8'd0; exp_state = 2'd0;
    next_pc = model_pc + 8'd1;
    case (op)
      3'd1: begin exp_ld = 1'b1; exp_load = tgt; end
      3'd4: if (zf) begin exp_ld = 1'b1; exp_load = tgt; end else exp_en = 1'b1;
      3'd2: if (model_stack.size() < 4) begin
              model_stack.push_back(next_pc);
              exp_ld = 1'b1; exp_load = tgt;
            end else begin
              model_ovf = 1'b1; exp_en = 1'b1;
            end
      3'd3: if (model_stack.size() > 0) begin
              exp_load = model_stack.pop_back();
              exp_ld = 1'b1;
            end else begin
              model_unf = 1'b1; exp_en = 1'b1;
            end
      3'd5: exp_state = 2'd3;
      default: exp_en = 1'b1;
    endcase
    op_class = op; target = tgt; zero_flag = zf; stall = 1'b0;
    for (int i = 0; i < waits; i++) begin
      instr_valid = 1'b0;
      #1;
      check("wait_ir", 32'(ir_load), 32'(0));
      check_idle("wait", 2'd0);
      step();
    end
    instr_valid = 1'b1;
    #1;
    check("fetch_ir", 32'(ir_load), 32'(1));
    check_idle("fetch", 2'd0);
    step();
    instr_valid = 1'($urandom_range(0, 1));
    stall = 1'($urandom_range(0, 1));
    #1;
    check("decode_ir", 32'(ir_load), 32'(0));
    check_idle("decode", 2'd1);
    step();
    for (int i = 0; i < stalls; i++) begin
      stall = 1'b1;
      #1;
      check_idle("stall", 2'd2);
      step();
    end
    stall = 1'b0;
    #1;
    check("exec_state", 32'(state), 32'(2));
    check("exec_en", 32'(en_PC), 32'(exp_en));
    check("exec_ld", 32'(load_en), 32'(exp_ld));
    check("exec_load", 32'(load), 32'(exp_load));
    step();
    if (exp_en) model_pc = model_pc + 8'd1;
    else if (exp_ld) model_pc = exp_load;
    #1;
    check("next_state", 32'(state), 32'(exp_state));
    check("next_halted", 32'(halted), 32'(exp_state == 2'd3));
    check_arch("retire");
  endtask

  initial begin
    logic [2:0] op;
    reset = 1'b1; instr_valid = 1'b0; op_class = 3'd0; target = 8'd0;
    zero_flag = 1'b0; stall = 1'b0;
    @(negedge clk);
    do_reset();

    // sequential flow, then jump at pc=5
    for (int i = 0; i < 5; i++) run_instr(3'd0, 8'($urandom), 1'b0, 0, 0);
    run_instr(3'd1, 8'h40, 1'b0, 0, 0);
    run_instr(3'd4, 8'h20, 1'b1, 1, 0);
    run_instr(3'd4, 8'h20, 1'b0, 0, 1);
    run_instr(3'd7, 8'h99, 1'b1, 0, 0);
    // return address wrap at pc=FF
    run_instr(3'd1, 8'hFF, 1'b0, 0, 0);
    run_instr(3'd2, 8'h10, 1'b0, 0, 0);
    run_instr(3'd3, 8'h77, 1'b0, 0, 0);
    // nesting beyond the stack depth, then unwinding past empty
    for (int i = 0; i < 5; i++) run_instr(3'd2, 8'(8'h30 + 8'(i * 16)), 1'b0, 0, 0);
    for (int i = 0; i < 5; i++) run_instr(3'd3, 8'h00, 1'b0, 0, 0);
    run_instr(3'd6, 8'h00, 1'b0, 0, 4);

    // reset in the middle of a stalled CALL
    run_instr(3'd2, 8'h50, 1'b0, 0, 0);
    op_class = 3'd2; target = 8'h60; instr_valid = 1'b1; stall = 1'b0;
    step();
    step();
    stall = 1'b1;
    step();
    #1;
    check_idle("midstall", 2'd2);
    step();
    do_reset();
    run_instr(3'd3, 8'h00, 1'b0, 0, 0);

    // randomized instruction stream
    for (int n = 0; n < 300; n++) begin
      op = 3'($urandom_range(0, 7));
      if (op == 3'd5) op = 3'd2;
      run_instr(op, 8'($urandom), 1'($urandom_range(0, 1)),
                ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 2)) : 0,
                ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 4)) : 0);
    end

    // halt is absorbing until reset
    run_instr(3'd5, 8'h12, 1'b1, 0, 1);
    for (int i = 0; i < 4; i++) begin
      instr_valid = 1'b1;
      op_class = 3'($urandom_range(0, 4));
      #1;
      check("halt_ir", 32'(ir_load), 32'(0));
      check("halt_flag", 32'(halted), 32'(1));
      check_idle("halt", 2'd3);
      step();
    end
    check_arch("halt");
    do_reset();
    run_instr(3'd0, 8'h00, 1'b0, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
